// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//
// Sequencer in front of the FIR core's coefficient port. It accepts a
// ready/valid stream of NUM_COEF signed taps (tap 0 first) and writes them into
// the core's coefficient SRAM over cin/caddr/cload. It then replays a read of
// every address in ascending order so the core can shift the taps into its
// local coefficient register.
//
// Handshake: a coefficient is transferred on a rising clk2 edge where
// coef_valid and coef_ready are both high. coef_ready is combinational and
// depends only on state, rst and abort, never on coef_valid. The source holds
// coef_in stable while coef_valid is high and the word has not been taken.
// The source may stall for any number of cycles.
//
// Optional build macro: COEF_CHECKSUM_EN adds the checksum output.
//
// Ports
//   clk2        core clock, rising edge
//   rst         synchronous, active-high reset
//   start       one-cycle load request, sampled only while idle
//   abort       cancels a load in progress (IDLE on the next edge, no done)
//   coef_in     signed coefficient
//   coef_valid  coef_in valid
//   coef_ready  loader accepts coef_in this cycle
//   cin         SRAM write data (registered)
//   caddr       SRAM address (registered)
//   cload       {WEN_n, CEN_n, load_active} (registered)
//   busy        high from the edge after start until the load ends (registered)
//   done        one-cycle pulse when a load completes (registered)
//   checksum    (COEF_CHECKSUM_EN only) sign-extended sum of accepted taps
module fir_coef_loader #(
  parameter int NUM_COEF = 64,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [DATA_W-1:0] cin,
  output logic [ADDR_W-1:0] caddr,
  output logic [2:0]        cload,
  output logic              busy,
  output logic              done
`ifdef COEF_CHECKSUM_EN
  ,
  output logic signed [DATA_W+ADDR_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    RD_REQ = 3'd2,
    RD_CAP = 3'd3,
    FINISH = 3'd4
  } state_t;

  // cload codes: bit 2 = WEN_n, bit 1 = CEN_n, bit 0 = load_active
  localparam logic [2:0] CLOAD_IDLE  = 3'b110;
  localparam logic [2:0] CLOAD_HOLD  = 3'b111;
  localparam logic [2:0] CLOAD_WRITE = 3'b001;
  localparam logic [2:0] CLOAD_READ  = 3'b100;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEF - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] cin_d;
  logic [ADDR_W-1:0] caddr_d;
  logic [2:0]        cload_d;
  logic              busy_d;
  logic              done_d;
  logic              accept;

  assign coef_ready = (state_q == WRITE) && !rst && !abort;
  assign accept     = coef_valid && coef_ready;

`ifdef COEF_CHECKSUM_EN
  logic signed [DATA_W+ADDR_W-1:0] sum_d;
  logic signed [DATA_W+ADDR_W-1:0] coef_sext;

  assign coef_sext = $signed({{ADDR_W{coef_in[DATA_W-1]}}, coef_in});
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin;
    caddr_d = caddr;
    cload_d = cload;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef COEF_CHECKSUM_EN
    sum_d   = checksum;
`endif

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = WRITE;
          cload_d = CLOAD_HOLD;
          busy_d  = 1'b1;
          idx_d   = '0;
`ifdef COEF_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      WRITE: begin
        if (accept) begin
          cin_d   = coef_in;
          caddr_d = idx_q;
          cload_d = CLOAD_WRITE;
`ifdef COEF_CHECKSUM_EN
          sum_d   = checksum + coef_sext;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = RD_REQ;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          // Stall: deselect the SRAM, keep the last written word on cin/caddr.
          cload_d = CLOAD_HOLD;
        end
      end

      RD_REQ: begin
        caddr_d = idx_q;
        cload_d = CLOAD_READ;
        state_d = RD_CAP;
      end

      RD_CAP: begin
        // Core captures SRAM Q during this cycle, so caddr must not move.
        cload_d = CLOAD_HOLD;
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD_REQ;
        end
      end

      FINISH: begin
        cload_d = CLOAD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        caddr_d = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort looks like reset to the core, except cin keeps its last value.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      cin_d   = cin;
      caddr_d = '0;
      cload_d = CLOAD_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef COEF_CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cin      <= '0;
      caddr    <= '0;
      cload    <= CLOAD_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef COEF_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cin      <= cin_d;
      caddr    <= caddr_d;
      cload    <= cload_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef COEF_CHECKSUM_EN
      checksum <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader. Drivers issue loads and push the expected SRAM
// writes, reads, done pulses and checksums into queues; an independent monitor
// pops and compares whenever the loader presents a write strobe, a read strobe
// or done. Build with +define+COEF_CHECKSUM_EN to cover the checksum output.
module tb_fir_coef_loader;
  localparam int NUM_COEF = 64;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;
  localparam int SUM_W    = DATA_W + ADDR_W;

  localparam logic [2:0] C_IDLE  = 3'b110;
  localparam logic [2:0] C_HOLD  = 3'b111;
  localparam logic [2:0] C_WRITE = 3'b001;
  localparam logic [2:0] C_READ  = 3'b100;

  // ---------------- clock / reset / DUT ----------------
  logic clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  logic              rst, start, abort, coef_valid, coef_ready;
  logic [DATA_W-1:0] coef_in, cin;
  logic [ADDR_W-1:0] caddr;
  logic [2:0]        cload;
  logic              busy, done;
`ifdef COEF_CHECKSUM_EN
  logic signed [SUM_W-1:0] checksum;
`endif

  fir_coef_loader #(.NUM_COEF(NUM_COEF), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk2       (clk2),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .cin        (cin),
    .caddr      (caddr),
    .cload      (cload),
    .busy       (busy),
    .done       (done)
`ifdef COEF_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];      // expected {caddr, cin} per write
  logic [ADDR_W-1:0]        exp_rd_q[$];   // expected caddr per read strobe
  logic                     exp_done_q[$]; // one token per load that must finish
  logic [SUM_W-1:0]         exp_sum_q[$];  // expected checksum at done

  logic signed [DATA_W-1:0] coef_tab[NUM_COEF];

  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int last_wr_cyc = 0, done_cyc = 0, start_cyc = 0;
  int wr0 = 0, rd0 = 0;
  logic [2:0]        prev_cload = 3'b000;
  logic [ADDR_W-1:0] prev_caddr = '0;
  logic              ctl_at_edge = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h required=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input int got);
    checks++;
    errors++;
    $display("FAIL %s got=%0d required=none (t=%0t)", name, got, $time);
  endtask

  initial forever begin
    @(posedge clk2);
    cyc++;
    ctl_at_edge = rst | abort;
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk2);
    if (prev_cload === C_READ && !ctl_at_edge) begin
      chk("hold_after_read", {29'd0, cload}, {29'd0, C_HOLD});
      chk("caddr_stable_rdcap", {26'd0, caddr}, {26'd0, prev_caddr});
    end
    if (cload === C_WRITE) begin
      if (exp_q.size() == 0) note_fail("unexpected_write", int'(caddr));
      else chk("write_addr_data", {10'd0, caddr, cin}, {10'd0, exp_q.pop_front()});
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (cload === C_READ) begin
      if (exp_rd_q.size() == 0) note_fail("unexpected_read", int'(caddr));
      else chk("read_addr", {26'd0, caddr}, {26'd0, exp_rd_q.pop_front()});
      chk("busy_in_read", {31'd0, busy}, 32'd1);
      rd_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_done_q.size() == 0) begin
        note_fail("unexpected_done", cyc);
      end else begin
        void'(exp_done_q.pop_front());
        chk("read_phase_cycles", 32'(cyc - last_wr_cyc), 32'd129);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("cload_at_done", {29'd0, cload}, {29'd0, C_IDLE});
        chk("caddr_at_done", {26'd0, caddr}, 32'd0);
`ifdef COEF_CHECKSUM_EN
        if (exp_sum_q.size() != 0)
          chk("checksum_at_done", {10'd0, checksum}, {10'd0, exp_sum_q.pop_front()});
`endif
      end
    end
    prev_cload = cload;
    prev_caddr = caddr;
  end

  // ---------------- driver tasks ----------------
  task automatic flush_queues();
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  // Called at a negedge while idle; returns at the negedge after the start edge.
  task automatic do_start(input bit expect_done);
    logic [SUM_W-1:0] s = '0;
    for (int k = 0; k < NUM_COEF; k++) begin
      exp_q.push_back({ADDR_W'(k), coef_tab[k]});
      exp_rd_q.push_back(ADDR_W'(k));
      s = s + {{ADDR_W{coef_tab[k][DATA_W-1]}}, coef_tab[k]};
    end
    if (expect_done) begin
      exp_done_q.push_back(1'b1);
      exp_sum_q.push_back(s);
    end
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    start = 1'b1;
    @(negedge clk2);
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("cload_hold_after_start", {29'd0, cload}, {29'd0, C_HOLD});
  endtask

  // Offers taps 0.. in order; stops early at stop_k (use -1 for a full load).
  task automatic feed(input int stall_pct, input int start_k, input int stop_k);
    int  k = 0;
    int  budget = 0;
    bit  acc;
    while (k < NUM_COEF && k != stop_k && budget < 3000) begin
      coef_valid = ($urandom_range(0, 99) >= stall_pct);
      coef_in    = coef_tab[k];
      start      = (k == start_k);
      #1;
      acc = coef_valid && coef_ready;
      if (stall_pct == 0) chk("ready_in_write", {31'd0, coef_ready}, 32'd1);
      @(negedge clk2);
      budget++;
      if (acc) k++;
      else chk("hold_on_stall", {29'd0, cload}, {29'd0, C_HOLD});
    end
    coef_valid = 1'b0;
    start      = 1'b0;
    if (budget >= 3000) note_fail("feed_timeout", k);
    else if (k == NUM_COEF) chk("ready_low_after_writes", {31'd0, coef_ready}, 32'd0);
  endtask

  task automatic finish_load(input int exp_latency, input bit pulse_start_rdcap);
    int budget = 0;
    int d0 = done_cnt;
    bit pulsed = 1'b0;
    while (done_cnt == d0 && budget < 400) begin
      @(negedge clk2);
      budget++;
      if (pulse_start_rdcap && !pulsed && cload === C_READ) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (budget >= 400) begin
      note_fail("done_timeout", budget);
    end else begin
      if (exp_latency > 0) chk("total_latency", 32'(done_cyc - start_cyc), 32'(exp_latency));
      chk("write_count", 32'(wr_cnt - wr0), 32'(NUM_COEF));
      chk("read_count", 32'(rd_cnt - rd0), 32'(NUM_COEF));
    end
    repeat (3) @(negedge clk2);
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    chk("write_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("read_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cload"}, {29'd0, cload}, {29'd0, C_IDLE});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_caddr"}, {26'd0, caddr}, 32'd0);
    chk({tag, "_coef_ready"}, {31'd0, coef_ready}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; coef_valid = 1'b0; coef_in = '0;
    repeat (3) @(negedge clk2);
    check_idle_outputs("por");
    chk("por_cin", {16'd0, cin}, 32'd0);
    rst = 1'b0;
    @(negedge clk2);

    for (int k = 0; k < NUM_COEF; k++) coef_tab[k] = 16'(k * 3 - 96);

    // 1: reset held for three cycles in the middle of the write phase
    do_start(1'b0);
    feed(0, -1, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk2);
    check_idle_outputs("rst_mid_write");
    rst = 1'b0;
    flush_queues();
    @(negedge clk2);
    chk("idle_ready_low", {31'd0, coef_ready}, 32'd0);

    // 2: zero-stall load, 193 cycles start to done
    do_start(1'b1);
    feed(0, -1, -1);
    finish_load(193, 1'b0);
`ifdef COEF_CHECKSUM_EN
    chk("checksum_ramp", {10'd0, checksum}, 32'h003F_FFA0);
`endif

    // 3: ~40% stalls on coef_valid
    do_start(1'b1);
    feed(40, -1, -1);
    finish_load(0, 1'b0);

    // 4: abort on the 10th read request, then a clean reload
    do_start(1'b0);
    feed(0, -1, -1);
    budget = 0;
    while (!(cload === C_READ && caddr === 6'd9) && budget < 400) begin
      @(negedge clk2);
      budget++;
    end
    if (budget >= 400) note_fail("abort_wait_timeout", budget);
    d0 = done_cnt;
    abort = 1'b1;
    @(negedge clk2);
    abort = 1'b0;
    check_idle_outputs("abort");
    chk("abort_cin_hold", {16'd0, cin}, {16'd0, coef_tab[NUM_COEF-1]});
`ifdef COEF_CHECKSUM_EN
    chk("abort_checksum_clear", {10'd0, checksum}, 32'd0);
`endif
    flush_queues();
    repeat (5) @(negedge clk2);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    do_start(1'b1);
    feed(0, -1, -1);
    finish_load(193, 1'b0);

    // 5: start while busy is ignored; start with abort in idle stays idle
    do_start(1'b1);
    feed(0, 20, -1);
    finish_load(193, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk2);
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start_abort_idle");
    repeat (3) @(negedge clk2);
    chk("start_abort_still_idle", {31'd0, busy}, 32'd0);

    // 6: full-scale alternating taps pass bit-exact
    for (int k = 0; k < NUM_COEF; k++) coef_tab[k] = (k % 2 == 0) ? 16'sh7FFF : 16'sh8000;
    do_start(1'b1);
    feed(0, -1, -1);
    finish_load(193, 1'b0);
`ifdef COEF_CHECKSUM_EN
    chk("checksum_extremes", {10'd0, checksum}, 32'h003F_FFE0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
